vga_sprite_renderer: RTL and testbench
======================================

# vga_sprite_renderer

Parametrised successor to the fixed-geometry field renderer. It generates its own VGA sync timing and renders N player discs, two rows of goal rings and the ball over a white field. Positions are double-buffered and committed once per frame, so sprites never tear. A 3-stage pixel pipeline replaces the single-cycle distance logic, and the sync/enable outputs are delayed to stay aligned with colour. It sits between the game-logic block (positions) and the DAC/VGA pins.

## Interface
- H_SYNC, 96: hsync pulse width, clocks
- H_BP, 48: horizontal back porch
- H_ACTIVE, 640: active pixels per line
- H_TOTAL, 800: clocks per line
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch
- V_ACTIVE, 480: active lines
- V_TOTAL, 525: lines per frame
- FIELD_W, 540: field width in active pixels; 1 px black separator, board occupies the remainder
- N_PLAYERS, 2: player discs; even index = blue team, odd index = red team
- PLAYER_X, {10'd560,10'd240}: packed fixed x centre per player, index 0 in LSBs
- N_GOALS, 3: goals per team
- GOAL_X0, 300 / GOAL_DX, 100: x of goal 0 and pitch between goals
- BLUE_GOAL_Y, 450 / RED_GOAL_Y, 100: goal row y centres
- PLAYER_RADIUS, 25 / GOAL_RADIUS, 40 / BALL_RADIUS, 5: sprite radii, px
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pos_valid  in  1  position update offered
- pos_ready  out  1  block can accept an update
- player_y  in  10*N_PLAYERS  packed player y centres, screen coordinates
- ball_x, ball_y  in  10 each  ball centre, screen coordinates
- hor_sync, ver_sync  out  1 each  active-low sync
- de  out  1  active-region pixel enable
- red, green, blue  out  8 each  pixel colour
- frame_tick  out  1  one-cycle pulse when shadow positions are committed

## Operation
- Counters: x counts 0..H_TOTAL-1. y increments when x wraps and counts 0..V_TOTAL-1. Sync comes first: sync asserted (low) while x<H_SYNC or y<V_SYNC.
- Active region: x in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1], same scheme for y. Defaults give 144..783 and 35..514.
- Field: active x < 144+FIELD_W. Separator column at x = 144+FIELD_W is black. Board (remaining active columns) is R=0x80, G=0xFF, B=0xAA. Outside the active region the colour is 0.
- Distance: dx = x − cx and dy = y − cy, both signed 11-bit. Squares are unsigned 21-bit; d2 = dx²+dy² is 22-bit. No wrap is permitted.
- Hit tests:
  - ball: d2 < BALL_RADIUS²
  - player: d2 ≤ PLAYER_RADIUS²
  - goal ring: (GOAL_RADIUS−2)² ≤ d2 ≤ (GOAL_RADIUS+2)²
- Field colour priority, first match wins:
  - ball → black
  - lowest-index player hit → blue team 0x0000FF, red team 0xFF0000
  - blue-row goal ring → blue
  - red-row goal ring → red
  - otherwise white 0xFFFFFF
- Position handshake:
  - Shadow registers load player_y, ball_x and ball_y on pos_valid && pos_ready.
  - pos_ready is 1 whenever not in reset.
  - Commit: live ← shadow on the cycle x==0 && y==0, with frame_tick=1 that cycle.
  - A capture in the commit cycle lands in shadow and is committed next frame; the commit copies the pre-capture shadow value.
- Reset values:
  - counters 0
  - shadow and live positions: player_y = 240, ball = (400,240)
  - hor_sync=0, ver_sync=0, de=0, rgb=0, frame_tick=0, pos_ready=0
- Reset mid-frame: all of the above apply immediately (asynchronously). The frame restarts at (0,0) on the first clock after release, and no commit occurs on that first edge.

## Timing
- Stage 0: counters. Stage 1: dx/dy and region decode. Stage 2: squares, sums, compares. Stage 3: priority mux into output registers.
- Colour, de, hor_sync and ver_sync all reflect counter value (x,y) exactly 3 clocks later; they stay mutually aligned.
- frame_tick is not delayed. It is asserted with the counter at (0,0).
- Live positions are stable for an entire frame. A change at the inputs appears on screen from the first active line after the next commit, no earlier.

## Structure
- Shared package vga_pkg: timing defaults, colour constants (WHITE, BLACK, BLUE, RED, BOARD) and a pure function sq11 (signed 11-bit → unsigned 21-bit).
- Sub-module vga_timing: the x/y counters, sync, de and frame_tick generation. The parent owns the shadow/live registers and the pixel pipeline, with generate loops over N_PLAYERS and N_GOALS.

## Test plan
- Reset release, no pos_valid → first hor_sync rising edge at output 3+96 clocks after release. Line period 800 clocks, frame period 420000 clocks. de high for 640 clocks per active line.
- ball=(400,240) committed → pixel (400,240) black; (404,240) black; (405,240) white.
- player_y[0]=300 → (240,300) and (240,325) blue; (240,326) white.
- Goal ring, blue row: (300,488) blue, (300,493) white, (300,450) white.
- Two pos_valid writes mid-frame (ball_x=200, then 210) → display unchanged until (0,0). frame_tick fires and the next frame shows ball at x=210. A write coincident with the commit appears one frame later.
- rst_n low at (500,300) for 5 clocks → outputs zero within the same cycle. After release, counters restart from 0 and positions return to defaults.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sprite renderer: default timing, colours,
// reset positions and the distance helpers used by the pixel pipeline.
package vga_pkg;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BOARD = 24'h80FFAA;

    localparam logic [9:0] DEF_PLAYER_Y = 10'd240;
    localparam logic [9:0] DEF_BALL_X   = 10'd400;
    localparam logic [9:0] DEF_BALL_Y   = 10'd240;

    typedef enum logic [1:0] {REG_BLANK, REG_FIELD, REG_SEP, REG_BOARD} region_e;

    // Magnitude first so -1024 squares correctly without a 22-bit multiplier.
    function automatic logic [20:0] sq11(input logic signed [10:0] v);
        logic [10:0] mag;
        logic [20:0] m21;
        mag = v[10] ? 11'(-v) : 11'(v);
        m21 = {10'd0, mag};
        return m21 * m21;
    endfunction

    function automatic logic signed [10:0] delta11(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with sync/enable decode; frame_tick marks the commit cycle
// at (0,0), suppressed on the reset-held pass through (0,0).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       de_o,
    output logic       tick_o,
    output logic       run_o
);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_END = 10'(H_SYNC);
    localparam logic [9:0] VS_END = 10'(V_SYNC);
    localparam logic [9:0] HA_BEG = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HA_END = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] VA_BEG = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VA_END = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       run_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q   <= '0;
            y_q   <= '0;
            run_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            run_q <= 1'b1;
        end
    end

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign hs_o   = !(x_q < HS_END);
    assign vs_o   = !(y_q < VS_END);
    assign de_o   = (x_q >= HA_BEG) && (x_q <= HA_END) && (y_q >= VA_BEG) && (y_q <= VA_END);
    assign tick_o = run_q && (x_q == '0) && (y_q == '0);
    assign run_o  = run_q;

endmodule

// File: rtl/vga_sprite_renderer.sv
// Field renderer: double-buffered sprite positions feeding a 3-stage pixel
// pipeline (delta/region, squares/compares, priority mux) with aligned sync.
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int H_SYNC        = H_SYNC_DEF,
    parameter int H_BP          = H_BP_DEF,
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int H_TOTAL       = H_TOTAL_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BP          = V_BP_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_TOTAL       = V_TOTAL_DEF,
    parameter int FIELD_W       = 540,
    parameter int N_PLAYERS     = 2,
    parameter logic [10*N_PLAYERS-1:0] PLAYER_X = {10'd560, 10'd240},
    parameter int N_GOALS       = 3,
    parameter int GOAL_X0       = 300,
    parameter int GOAL_DX       = 100,
    parameter int BLUE_GOAL_Y   = 450,
    parameter int RED_GOAL_Y    = 100,
    parameter int PLAYER_RADIUS = 25,
    parameter int GOAL_RADIUS   = 40,
    parameter int BALL_RADIUS   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pos_valid,
    output logic                    pos_ready,
    input  logic [10*N_PLAYERS-1:0] player_y,
    input  logic [9:0]              ball_x,
    input  logic [9:0]              ball_y,
    output logic                    hor_sync,
    output logic                    ver_sync,
    output logic                    de,
    output logic [7:0]              red,
    output logic [7:0]              green,
    output logic [7:0]              blue,
    output logic                    frame_tick
);
    localparam logic [9:0]  FIELD_END = 10'(H_SYNC + H_BP + FIELD_W);
    localparam logic [9:0]  BLUE_GY   = 10'(BLUE_GOAL_Y);
    localparam logic [9:0]  RED_GY    = 10'(RED_GOAL_Y);
    localparam logic [21:0] BALL_R2   = 22'(BALL_RADIUS * BALL_RADIUS);
    localparam logic [21:0] PLAYER_R2 = 22'(PLAYER_RADIUS * PLAYER_RADIUS);
    localparam logic [21:0] RING_IN2  = 22'((GOAL_RADIUS - 2) * (GOAL_RADIUS - 2));
    localparam logic [21:0] RING_OUT2 = 22'((GOAL_RADIUS + 2) * (GOAL_RADIUS + 2));

    logic [9:0] cnt_x, cnt_y;
    logic       raw_hs, raw_vs, raw_de;

    vga_timing #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
    ) u_timing (
        .clk_i(clk), .rst_ni(rst_n), .x_o(cnt_x), .y_o(cnt_y),
        .hs_o(raw_hs), .vs_o(raw_vs), .de_o(raw_de), .tick_o(frame_tick), .run_o(pos_ready)
    );

    // Shadow takes updates any time; live changes only at the frame commit.
    logic [10*N_PLAYERS-1:0] sh_py_q, sh_py_d, lv_py_q, lv_py_d;
    logic [9:0]              sh_bx_q, sh_bx_d, sh_by_q, sh_by_d;
    logic [9:0]              lv_bx_q, lv_bx_d, lv_by_q, lv_by_d;

    always_comb begin
        sh_py_d = sh_py_q;
        sh_bx_d = sh_bx_q;
        sh_by_d = sh_by_q;
        lv_py_d = lv_py_q;
        lv_bx_d = lv_bx_q;
        lv_by_d = lv_by_q;
        if (pos_valid && pos_ready) begin
            sh_py_d = player_y;
            sh_bx_d = ball_x;
            sh_by_d = ball_y;
        end
        if (frame_tick) begin
            lv_py_d = sh_py_q;
            lv_bx_d = sh_bx_q;
            lv_by_d = sh_by_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_py_q <= {N_PLAYERS{DEF_PLAYER_Y}};
            lv_py_q <= {N_PLAYERS{DEF_PLAYER_Y}};
            sh_bx_q <= DEF_BALL_X;
            sh_by_q <= DEF_BALL_Y;
            lv_bx_q <= DEF_BALL_X;
            lv_by_q <= DEF_BALL_Y;
        end else begin
            sh_py_q <= sh_py_d;
            lv_py_q <= lv_py_d;
            sh_bx_q <= sh_bx_d;
            sh_by_q <= sh_by_d;
            lv_bx_q <= lv_bx_d;
            lv_by_q <= lv_by_d;
        end
    end

    // Stage 1: region decode and signed deltas; stage 2: squared distance compares.
    region_e           region_d, region_p1_q, region_p2_q;
    logic [2:0]        sync_p1_q, sync_p2_q, sync_p3_q;
    logic signed [10:0] bdx_p1_q, bdy_p1_q;
    logic [21:0]       ball_d2;
    logic              ball_hit_p2_q;
    logic [N_PLAYERS-1:0] player_hit_p2;
    logic [N_GOALS-1:0]   blue_ring_p2, red_ring_p2;
    logic [23:0]       rgb_d, rgb_p3_q;

    always_comb begin
        if (!raw_de)                region_d = REG_BLANK;
        else if (cnt_x < FIELD_END) region_d = REG_FIELD;
        else if (cnt_x == FIELD_END) region_d = REG_SEP;
        else                        region_d = REG_BOARD;
    end

    assign ball_d2 = 22'(sq11(bdx_p1_q)) + 22'(sq11(bdy_p1_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_p1_q   <= REG_BLANK;
            region_p2_q   <= REG_BLANK;
            sync_p1_q     <= '0;
            sync_p2_q     <= '0;
            bdx_p1_q      <= '0;
            bdy_p1_q      <= '0;
            ball_hit_p2_q <= 1'b0;
        end else begin
            region_p1_q   <= region_d;
            region_p2_q   <= region_p1_q;
            sync_p1_q     <= {raw_hs, raw_vs, raw_de};
            sync_p2_q     <= sync_p1_q;
            bdx_p1_q      <= delta11(cnt_x, lv_bx_q);
            bdy_p1_q      <= delta11(cnt_y, lv_by_q);
            ball_hit_p2_q <= ball_d2 < BALL_R2;
        end
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        logic signed [10:0] dx_p1_q, dy_p1_q;
        logic [21:0]        d2;
        logic               hit_p2_q;

        assign d2 = 22'(sq11(dx_p1_q)) + 22'(sq11(dy_p1_q));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dx_p1_q  <= '0;
                dy_p1_q  <= '0;
                hit_p2_q <= 1'b0;
            end else begin
                dx_p1_q  <= delta11(cnt_x, PLAYER_X[10*i +: 10]);
                dy_p1_q  <= delta11(cnt_y, lv_py_q[10*i +: 10]);
                hit_p2_q <= d2 <= PLAYER_R2;
            end
        end

        assign player_hit_p2[i] = hit_p2_q;
    end

    for (genvar g = 0; g < N_GOALS; g++) begin : g_goal
        localparam logic [9:0] GX = 10'(GOAL_X0 + g * GOAL_DX);
        logic signed [10:0] dx_p1_q, dby_p1_q, dry_p1_q;
        logic [21:0]        d2_blue, d2_red;
        logic               blue_p2_q, red_p2_q;

        assign d2_blue = 22'(sq11(dx_p1_q)) + 22'(sq11(dby_p1_q));
        assign d2_red  = 22'(sq11(dx_p1_q)) + 22'(sq11(dry_p1_q));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dx_p1_q   <= '0;
                dby_p1_q  <= '0;
                dry_p1_q  <= '0;
                blue_p2_q <= 1'b0;
                red_p2_q  <= 1'b0;
            end else begin
                dx_p1_q   <= delta11(cnt_x, GX);
                dby_p1_q  <= delta11(cnt_y, BLUE_GY);
                dry_p1_q  <= delta11(cnt_y, RED_GY);
                blue_p2_q <= (d2_blue >= RING_IN2) && (d2_blue <= RING_OUT2);
                red_p2_q  <= (d2_red >= RING_IN2) && (d2_red <= RING_OUT2);
            end
        end

        assign blue_ring_p2[g] = blue_p2_q;
        assign red_ring_p2[g]  = red_p2_q;
    end

    // Stage 3: later assignments win, so the loop runs from lowest priority up.
    always_comb begin
        rgb_d = BLACK;
        case (region_p2_q)
            REG_FIELD: begin
                rgb_d = WHITE;
                if (|red_ring_p2)  rgb_d = RED;
                if (|blue_ring_p2) rgb_d = BLUE;
                for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                    if (player_hit_p2[i]) rgb_d = (i % 2 == 1) ? RED : BLUE;
                end
                if (ball_hit_p2_q) rgb_d = BLACK;
            end
            REG_BOARD: rgb_d = BOARD;
            default:   rgb_d = BLACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p3_q <= '0;
            rgb_p3_q  <= '0;
        end else begin
            sync_p3_q <= sync_p2_q;
            rgb_p3_q  <= rgb_d;
        end
    end

    assign {hor_sync, ver_sync, de} = sync_p3_q;
    assign {red, green, blue}       = rgb_p3_q;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Randomized bench for vga_sprite_renderer on a reduced raster, checked every
// cycle against a per-pixel geometric reference model.
module tb_vga_sprite_renderer;

    localparam int H_SYNC = 8, H_BP = 4, H_ACTIVE = 64, H_TOTAL = 80;
    localparam int V_SYNC = 2, V_BP = 3, V_ACTIVE = 40, V_TOTAL = 48;
    localparam int FIELD_W = 50, NP = 2, NG = 3;
    localparam int GOAL_X0 = 20, GOAL_DX = 15, BLUE_GOAL_Y = 40, RED_GOAL_Y = 10;
    localparam int PR = 6, GR = 8, BR = 3;
    localparam int PX0 = 25, PX1 = 45;
    localparam logic [19:0] PLAYER_X = {10'd45, 10'd25};
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int HA0 = H_SYNC + H_BP;
    localparam int VA0 = V_SYNC + V_BP;

    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_BLUE  = 24'h0000FF;
    localparam logic [23:0] C_RED   = 24'hFF0000;
    localparam logic [23:0] C_BOARD = 24'h80FFAA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic [19:0] player_y = '0;
    logic [9:0]  ball_x = '0, ball_y = '0;
    logic        hor_sync, ver_sync, de, frame_tick;
    logic [7:0]  red, green, blue;

    vga_sprite_renderer #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
        .FIELD_W(FIELD_W), .N_PLAYERS(NP), .PLAYER_X(PLAYER_X), .N_GOALS(NG),
        .GOAL_X0(GOAL_X0), .GOAL_DX(GOAL_DX), .BLUE_GOAL_Y(BLUE_GOAL_Y),
        .RED_GOAL_Y(RED_GOAL_Y), .PLAYER_RADIUS(PR), .GOAL_RADIUS(GR), .BALL_RADIUS(BR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pos_valid(pos_valid), .pos_ready(pos_ready),
        .player_y(player_y), .ball_x(ball_x), .ball_y(ball_y),
        .hor_sync(hor_sync), .ver_sync(ver_sync), .de(de),
        .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int m_sh_py[NP];
    int m_lv_py[NP];
    int m_sh_bx, m_sh_by, m_lv_bx, m_lv_by;
    logic [26:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h expected=%h", tag, n, got, exp);
        end
    endtask

    function automatic int dsq(int x, int y, int cx, int cy);
        return (x - cx) * (x - cx) + (y - cy) * (y - cy);
    endfunction

    function automatic logic [23:0] field_colour(int x, int y);
        int d;
        if (dsq(x, y, m_lv_bx, m_lv_by) < BR * BR) return 24'h000000;
        for (int i = 0; i < NP; i++)
            if (dsq(x, y, (i == 0) ? PX0 : PX1, m_lv_py[i]) <= PR * PR)
                return (i % 2 == 1) ? C_RED : C_BLUE;
        for (int g = 0; g < NG; g++) begin
            d = dsq(x, y, GOAL_X0 + g * GOAL_DX, BLUE_GOAL_Y);
            if (d >= (GR - 2) * (GR - 2) && d <= (GR + 2) * (GR + 2)) return C_BLUE;
        end
        for (int g = 0; g < NG; g++) begin
            d = dsq(x, y, GOAL_X0 + g * GOAL_DX, RED_GOAL_Y);
            if (d >= (GR - 2) * (GR - 2) && d <= (GR + 2) * (GR + 2)) return C_RED;
        end
        return C_WHITE;
    endfunction

    // {hsync, vsync, de, rgb} for raster position index c within a frame.
    function automatic logic [26:0] ref_pixel(int c);
        int x, y;
        logic hs, vs, act;
        logic [23:0] col;
        x   = c % H_TOTAL;
        y   = c / H_TOTAL;
        hs  = (x >= H_SYNC);
        vs  = (y >= V_SYNC);
        act = (x >= HA0) && (x < HA0 + H_ACTIVE) && (y >= VA0) && (y < VA0 + V_ACTIVE);
        col = 24'h0;
        if (act) begin
            if (x > HA0 + FIELD_W)       col = C_BOARD;
            else if (x == HA0 + FIELD_W) col = 24'h0;
            else                         col = field_colour(x, y);
        end
        return {hs, vs, act, col};
    endfunction

    task automatic model_init();
        for (int i = 0; i < NP; i++) begin
            m_sh_py[i] = 240;
            m_lv_py[i] = 240;
        end
        m_sh_bx = 400; m_sh_by = 240;
        m_lv_bx = 400; m_lv_by = 240;
        exp_q.delete();
        n = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix"}, 32'({hor_sync, ver_sync, de, red, green, blue}), 32'd0);
        check({tag, "_ctl"}, 32'({frame_tick, pos_ready}), 32'd0);
    endtask

    // One clock: advance the model at the edge, compare just after, then drive.
    task automatic step();
        logic [26:0] e;
        @(posedge clk);
        n++;
        exp_q.push_back(ref_pixel((n - 1) % FRAME));
        if ((n - 1) % FRAME == 0 && n - 1 >= 1) begin
            m_lv_py = m_sh_py;
            m_lv_bx = m_sh_bx;
            m_lv_by = m_sh_by;
        end
        if (pos_valid && n - 1 >= 1) begin
            for (int i = 0; i < NP; i++) m_sh_py[i] = int'(player_y[10*i +: 10]);
            m_sh_bx = int'(ball_x);
            m_sh_by = int'(ball_y);
        end
        #1;
        e = (n >= 3) ? exp_q.pop_front() : 27'd0;
        check("sync_de", 32'({hor_sync, ver_sync, de}), 32'(e[26:24]));
        check("rgb", 32'({red, green, blue}), 32'(e[23:0]));
        check("frame_tick", 32'(frame_tick), 32'(n % FRAME == 0));
        check("pos_ready", 32'(pos_ready), 32'd1);

        pos_valid = 1'b0;
        if (n == 3 * FRAME) begin
            pos_valid = 1'b1;
            ball_x    = 10'd30;
            ball_y    = 10'd20;
            player_y  = {10'd25, 10'd30};
        end else if (n > 4 && (n / FRAME) != 3 && $urandom_range(0, 799) == 0) begin
            pos_valid = 1'b1;
            ball_x    = 10'($urandom_range(5, 85));
            ball_y    = 10'($urandom_range(0, 50));
            player_y  = {10'($urandom_range(0, 50)), 10'($urandom_range(0, 50))};
        end
    endtask

    initial begin
        model_init();
        #12;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #2 rst_n = 1'b1;

        while (n < 6 * FRAME + 30 * H_TOTAL + 50) step();

        rst_n     = 1'b0;
        pos_valid = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        #1 rst_n = 1'b1;
        model_init();

        while (n < 3 * FRAME + 10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
